// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmitter and receiver
//
// Contents:
//   uart_state_t       frame state enum {IDLE, START, DATA, PARITY, STOP}
//   NBITS_6/7/8        character length encodings carried on NBits
//   OVERSAMPLE_DEFAULT Tick pulses per bit period, common to tx and rx
//   char_len()         maps an NBits code to a data bit count (unknown codes -> 8)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic [3:0] NBITS_6 = 4'd6;
  localparam logic [3:0] NBITS_7 = 4'd7;
  localparam logic [3:0] NBITS_8 = 4'd8;

  localparam int OVERSAMPLE_DEFAULT = 16;

  function automatic logic [3:0] char_len(input logic [3:0] nbits);
    case (nbits)
      NBITS_6: return NBITS_6;
      NBITS_7: return NBITS_7;
      default: return NBITS_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, 6/7/8 data bits LSB first, optional parity, one stop bit
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// Ports:
//   Clk      system clock
//   Rst      synchronous active-high reset; aborts any frame in progress
//   TxEn     enables acceptance of new requests (does not abort a running frame)
//   Tick     one-Clk oversample enable, OVERSAMPLE pulses per bit period
//   NBits    character length code (6, 7, 8; anything else sends 8)
//   TxStart  send request, accepted when idle and TxEn is high
//   TxData   character to send, bit 0 first
//   Tx       registered serial output, idles high
//   Busy     frame in progress (also high during the TxDone cycle)
//   TxDone   one-Clk pulse after the stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_MAX   = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                TxEn,
  input  logic                Tick,
  input  logic [3:0]          NBits,
  input  logic                TxStart,
  input  logic [DATA_MAX-1:0] TxData,
  output logic                Tx,
  output logic                Busy,
  output logic                TxDone
);

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  uart_state_t         state_q, state_d;
  logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          len_q, len_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                accept;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // Acceptance only needs the state to be IDLE, which also covers the TxDone
  // cycle: a request there chains straight into the next start bit.
  assign accept  = TxStart & TxEn & (state_q == IDLE);
  assign bit_end = Tick & (tick_cnt_q == CNT_LAST);

  assign Tx     = tx_q;
  assign Busy   = (state_q != IDLE) | done_q;
  assign TxDone = done_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    // Ticks are only counted inside a frame, so a Tick in the accept cycle is ignored.
    if ((state_q != IDLE) && Tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          len_d      = char_len(NBits);
          shift_d    = TxData;
`ifdef UART_TX_PARITY_EN
          parity_d   = 1'b0;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
          parity_d = parity_q ^ shift_q[0];
`endif
          if (bit_cnt_q == len_q - 4'd1) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so Tx changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: randomized frames checked against a bit-level line model
module tb_uart_tx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       tx_en    = 1'b0;
  logic       tick     = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] nbits    = 4'd8;
  logic [7:0] tx_data  = 8'h00;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx #(.OVERSAMPLE(OS), .DATA_MAX(8)) dut (
    .Clk    (clk),
    .Rst    (rst),
    .TxEn   (tx_en),
    .Tick   (tick),
    .NBits  (nbits),
    .TxStart(tx_start),
    .TxData (tx_data),
    .Tx     (tx),
    .Busy   (busy),
    .TxDone (tx_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] nbits;
    int         start_cyc;
    bit         chained;
  } frame_t;

  frame_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference line: start 0, len data bits LSB first, optional even parity, stop 1.
  function automatic int build(input logic [7:0] d, input logic [3:0] nb, output logic b [0:11]);
    int len;
    int ones;
    len  = (nb == 4'd6) ? 6 : (nb == 4'd7) ? 7 : 8;
    ones = 0;
    for (int i = 0; i < 12; i++) b[i] = 1'b1;
    b[0] = 1'b0;
    for (int i = 0; i < len; i++) begin
      b[1 + i] = d[i];
      ones += int'(d[i]);
    end
    if (PAR_BITS == 1) b[len + 1] = logic'(ones % 2);
    return len + 2 + PAR_BITS;
  endfunction

  function automatic int frame_clks(input logic [3:0] nb);
    int len;
    len = (nb == 4'd6) ? 6 : (nb == 4'd7) ? 7 : 8;
    return (len + 2 + PAR_BITS) * OS * TICK_DIV;
  endfunction

  // Cycle counter: cyc names the cycle that begins at the latest posedge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  bit tick_on = 1'b1;
  int tdiv    = 0;
  initial forever begin
    @(posedge clk);
    #1;
    tdiv = (tdiv + 1) % TICK_DIV;
    tick = tick_on && (tdiv == 0);
  end

  // Monitor: every bit of the expected line lasts exactly OS observed ticks.
  bit     active       = 1'b0;
  logic   cur_bits [0:11];
  int     cur_n        = 0;
  int     bit_i        = 0;
  int     tk           = 0;
  int     done_exp_cyc = -1;
  int     last_done_cyc = -1;
  frame_t mon_f;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      active       = 1'b0;
      done_exp_cyc = -1;
    end else begin
      if (!active && sb.size() > 0 && sb[0].start_cyc == cyc) begin
        mon_f  = sb.pop_front();
        cur_n  = build(mon_f.data, mon_f.nbits, cur_bits);
        active = 1'b1;
        bit_i  = 0;
        tk     = 0;
      end
      if (tx_done) last_done_cyc = cyc;
      if (active) begin
        chk("tx_bit", int'(tx), int'(cur_bits[bit_i]));
        chk("busy_in_frame", int'(busy), 1);
        chk("done_in_frame", int'(tx_done), 0);
        if (tick) begin
          tk++;
          if (tk == OS) begin
            tk = 0;
            bit_i++;
            if (bit_i == cur_n) begin
              active       = 1'b0;
              done_exp_cyc = cyc + 1;
              if (sb.size() > 0 && sb[0].chained) sb[0].start_cyc = cyc + 2;
            end
          end
        end
      end else begin
        chk("tx_idle", int'(tx), 1);
        chk("done_pulse", int'(tx_done), int'(cyc == done_exp_cyc));
        if (cyc == done_exp_cyc) begin
          if (sb.size() > 0 && sb[0].chained) chk("busy_chain", int'(busy), 1);
        end else begin
          chk("busy_idle", int'(busy), 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((sb.size() > 0 || active || cyc <= done_exp_cyc) && n < 3000) begin
      step();
      n++;
    end
    chk("quiet_timeout", int'(n < 3000), 1);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick && n < 16) begin
      step();
      n++;
    end
    chk("tick_timeout", int'(n < 16), 1);
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] nb, input bit align, output int acc);
    frame_t f;
    wait_quiet();
    if (align) wait_tick();
    tx_en    = 1'b1;
    tx_start = 1'b1;
    tx_data  = d;
    nbits    = nb;
    f.data      = d;
    f.nbits     = nb;
    f.start_cyc = cyc + 1;
    f.chained   = 1'b0;
    sb.push_back(f);
    acc = cyc;
    step();
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    nbits    = 4'($urandom);
  endtask

  task automatic send_timed(input logic [7:0] d, input logic [3:0] nb, input string name);
    int acc;
    send(d, nb, 1'b1, acc);
    wait_quiet();
    chk(name, last_done_cyc - (acc + 1), frame_clks(nb));
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int     acc;
    int     n;
    frame_t f;
    logic [7:0] d;
    logic [3:0] nb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(tx_done), 0);
    step();
    rst   = 1'b0;
    tx_en = 1'b1;
    repeat (20) step();

    send_timed(8'hA5, 4'd8, "latency_8bit");
    send_timed(8'hFF, 4'd6, "latency_6bit");
    send_timed(8'h5A, 4'd3, "latency_nbits3");
    send_timed(8'h07, 4'd8, "latency_par07");
    send_timed(8'h03, 4'd8, "latency_par03");
    send_timed(8'hC3, 4'd7, "latency_7bit");

    // Requests while busy are ignored and do not disturb the frame.
    send(8'h3C, 4'd8, 1'b0, acc);
    repeat (100) step();
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    nbits    = 4'd6;
    repeat (5) step();
    tx_start = 1'b0;
    wait_quiet();

    // Back-to-back: TxStart held, second frame chains off the TxDone cycle.
    wait_quiet();
    wait_tick();
    tx_start = 1'b1;
    tx_data  = 8'h00;
    nbits    = 4'd8;
    f.data = 8'h00; f.nbits = 4'd8; f.start_cyc = cyc + 1; f.chained = 1'b0;
    sb.push_back(f);
    f.data = 8'hFF; f.nbits = 4'd8; f.start_cyc = -1; f.chained = 1'b1;
    sb.push_back(f);
    acc = cyc;
    step();
    tx_data = 8'hFF;
    n = 0;
    while (!tx_done && n < 2000) begin
      step();
      n++;
    end
    chk("chain_first_done", int'(n < 2000), 1);
    step();
    tx_start = 1'b0;
    wait_quiet();
    chk("chain_total", last_done_cyc - (acc + 1) >= 2 * frame_clks(4'd8) - TICK_DIV, 1);

    // Reset in the middle of data bit 3 aborts the frame.
    send(8'h96, 4'd8, 1'b1, acc);
    while (cyc < acc + 1 + 4 * OS * TICK_DIV + 20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(tx_done), 0);
    n = last_done_cyc;
    repeat (800) step();
    chk("abort_no_done", last_done_cyc, n);
    send_timed(8'h5A, 4'd8, "latency_after_abort");

    // TxEn low gates new requests.
    tx_en    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'h00;
    repeat (100) step();
    chk("gated_busy", int'(busy), 0);
    chk("gated_tx", int'(tx), 1);
    tx_start = 1'b0;
    tx_en    = 1'b1;

    // TxEn dropped mid-frame: frame still completes.
    send(8'h81, 4'd8, 1'b1, acc);
    repeat (30) step();
    tx_en = 1'b0;
    wait_quiet();
    chk("en_drop_done", last_done_cyc - (acc + 1), frame_clks(4'd8));
    tx_en = 1'b1;

    // Tick stall mid-frame: line holds, bit timing resumes with the ticks.
    send(8'h6B, 4'd7, 1'b1, acc);
    repeat (150) step();
    tick_on = 1'b0;
    repeat (300) step();
    tick_on = 1'b1;
    wait_quiet();
    chk("stall_done", last_done_cyc - (acc + 1), frame_clks(4'd7) + 300);

    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(6, 8));
      send(d, nb, bit'($urandom_range(0, 1)), acc);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(20, 300)) step();
        tx_start = 1'b1;
        tx_data  = 8'($urandom);
        step();
        tx_start = 1'b0;
      end
      wait_quiet();
      repeat ($urandom_range(0, 10)) step();
    end

    wait_quiet();
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
